clint_mc: RTL

- Parametrised successor to the core-local interrupt controller. It arbitrates NUM_IRQ interrupt lines plus ECALL/EBREAK/MRET.
- On entry to a trap it sequences the MEPC, MSTATUS and MCAUSE CSR writes, then redirects the core through ex. On MRET it restores MSTATUS and returns to MEPC.
- New versus the previous generation:
  - N interrupt lines, each configurable as edge or level.
  - Fixed-priority arbitration.
  - Per-line mask.
  - Per-line cause codes.
  - Optional vectored mtvec mode.
  - Claim pulse back to the interrupt sources.

---
 rtl/clint_mc.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/clint_mc.sv
// clint_mc: core-local interrupt controller with NUM_IRQ external lines.
// Arbitrates ECALL/EBREAK, external interrupts and MRET. On a trap it
// writes MEPC, MSTATUS and MCAUSE on consecutive cycles, then redirects
// the core. On MRET it restores MSTATUS and redirects to MEPC.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   irq_i              raw interrupt lines (edge or level per EDGE_MASK)
//   irq_mask_i         per-line enable
//   global_int_en_i    mstatus.MIE
//   inst_i/inst_addr_i instruction in decode and its address
//   jump_flag_i/addr   jump taken in execute and its target
//   div_started_i      divider busy
//   csr_mtvec/mepc/mstatus  current CSR values
//   hold_flag_o        pipeline hold
//   we_o/waddr_o/data_o CSR write port
//   int_assert_o/int_addr_o  one-cycle redirect to execute
//   irq_claim_o        one-hot acknowledgement of the taken line
module clint_mc #(
  parameter int unsigned        NUM_IRQ        = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK      = '0,
  parameter int unsigned        IRQ_CAUSE_BASE = 16,
  parameter bit                 VECTOR_EN      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               div_started_i,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  input  logic [31:0]        csr_mstatus,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [NUM_IRQ-1:0] irq_claim_o
);

  localparam int unsigned IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MSTATUS = 3'd2,
    W_MCAUSE  = 3'd3,
    JUMP      = 3'd4,
    W_MRET    = 3'd5
  } state_t;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic logic [IDXW-1:0] lowest_index(input logic [NUM_IRQ-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDXW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        cause_q, cause_d;
  logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] irq_hist_q;

  logic               we_q, we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [31:0]        data_q, data_d;
  logic               int_assert_q, int_assert_d;
  logic [31:0]        int_addr_q, int_addr_d;
  logic [NUM_IRQ-1:0] claim_q, claim_d;

  logic               is_ecall_s, is_ebreak_s, is_mret_s;
  logic               sync_req_s, async_req_s, mret_req_s, accept_s;
  logic [NUM_IRQ-1:0] pending_s, eligible_s;
  logic [IDXW-1:0]    winner_s;
  logic [NUM_IRQ-1:0] winner_oh_s;
  logic [31:0]        mtvec_base_s;

  assign is_ecall_s  = (inst_i == INST_ECALL);
  assign is_ebreak_s = (inst_i == INST_EBREAK);
  assign is_mret_s   = (inst_i == INST_MRET);

  // Edge lines use the latched pending bit; level lines follow the pin.
  assign pending_s   = (edge_pend_q & EDGE_MASK) | (irq_i & ~EDGE_MASK);
  assign eligible_s  = pending_s & irq_mask_i;
  assign winner_s    = lowest_index(eligible_s);
  assign winner_oh_s = NUM_IRQ'(1'b1) << winner_s;

  assign sync_req_s  = (state_q == IDLE) & (is_ecall_s | is_ebreak_s) & ~div_started_i;
  assign async_req_s = (state_q == IDLE) & (|eligible_s) & global_int_en_i;
  assign mret_req_s  = (state_q == IDLE) & is_mret_s;
  assign accept_s    = sync_req_s | async_req_s | mret_req_s;

  assign hold_flag_o = (state_q != IDLE) | accept_s;

  assign mtvec_base_s = {csr_mtvec[31:2], 2'b00};

  // Next state, trap context capture and claim generation.
  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    claim_d     = '0;
    case (state_q)
      IDLE: begin
        if (sync_req_s) begin
          state_d = W_MEPC;
          epc_d   = jump_flag_i ? (jump_addr_i - 32'd4) : inst_addr_i;
          cause_d = is_ecall_s ? 32'd11 : 32'd3;
        end else if (async_req_s) begin
          state_d = W_MEPC;
          if (jump_flag_i) begin
            epc_d = jump_addr_i;
          end else if (div_started_i) begin
            epc_d = inst_addr_i - 32'd4;
          end else begin
            epc_d = inst_addr_i;
          end
          cause_d = 32'h8000_0000 | (32'(IRQ_CAUSE_BASE) + 32'(winner_s));
          claim_d = winner_oh_s;
        end else if (mret_req_s) begin
          state_d = W_MRET;
        end else begin
          state_d = IDLE;
        end
      end
      W_MEPC:    state_d = W_MSTATUS;
      W_MSTATUS: state_d = W_MCAUSE;
      W_MCAUSE:  state_d = JUMP;
      JUMP:      state_d = IDLE;
      W_MRET:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Edge pending bits: set on a rising edge, cleared only by a claim.
  always_comb begin
    edge_pend_d = ((edge_pend_q | (irq_i & ~irq_hist_q)) & ~claim_d) & EDGE_MASK;
  end

  // Output values decoded from the state being entered, registered below.
  always_comb begin
    we_d         = 1'b0;
    waddr_d      = 32'h0;
    data_d       = 32'h0;
    int_assert_d = 1'b0;
    int_addr_d   = 32'h0;
    case (state_d)
      W_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = epc_d;
      end
      W_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = mstatus_trap(csr_mstatus);
      end
      W_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_q;
      end
      JUMP: begin
        int_assert_d = 1'b1;
        if (VECTOR_EN && (csr_mtvec[1:0] == 2'b01) && cause_q[31]) begin
          int_addr_d = mtvec_base_s + ((cause_q & 32'h7FFF_FFFF) << 2);
        end else begin
          int_addr_d = mtvec_base_s;
        end
      end
      W_MRET: begin
        we_d         = 1'b1;
        waddr_d      = CSR_MSTATUS;
        data_d       = mstatus_mret(csr_mstatus);
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // State, context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      epc_q        <= 32'h0;
      cause_q      <= 32'h0;
      edge_pend_q  <= '0;
      irq_hist_q   <= '0;
      we_q         <= 1'b0;
      waddr_q      <= 32'h0;
      data_q       <= 32'h0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'h0;
      claim_q      <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      edge_pend_q  <= edge_pend_d;
      irq_hist_q   <= irq_i;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
      claim_q      <= claim_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;
  assign irq_claim_o  = claim_q;

endmodule
